// File: rtl/avr_io_irqctl.sv
// avr_io_irqctl: programmable interrupt controller on the AVR I/O bus.
// Latches up to N_IRQ peripheral requests with per-source mask and level/edge
// mode, presents a single iflag/ivect pair to the core, and retires edge
// requests on the core's acknowledge or by write-1-to-clear.
// Register map: 0 PEND, 1 MASK, 2 EDGE, 3 STAT.
// Optional feature: define IRQCTL_ROTATE_EN for round-robin priority; otherwise
// fixed priority with the lowest index winning.
module avr_io_irqctl #(
  parameter int unsigned N_IRQ  = 4,
  parameter int unsigned VECT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_re,
  input  logic              io_we,
  input  logic [1:0]        io_a,
  input  logic [7:0]        io_di,
  output logic [7:0]        io_do,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              irq_ack,
  input  logic [VECT_W-1:0] irq_ack_vect,
  output logic              iflag,
  output logic [VECT_W-1:0] ivect
);

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_EDGE = 2'd2,
    REG_STAT = 2'd3
  } reg_e;

  logic [N_IRQ-1:0]  pending;
  logic [N_IRQ-1:0]  enable;
  logic [N_IRQ-1:0]  mode;
  logic [N_IRQ-1:0]  irq_q;
  logic [N_IRQ-1:0]  pending_nxt;
  logic [N_IRQ-1:0]  req;
  logic [VECT_W-1:0] win;
  logic              found;
  logic              wr_pend;
  logic              wr_mask;
  logic              wr_edge;

  // Upper data bits only matter when N_IRQ < 8; they are deliberately ignored.
  logic unused_di;
  assign unused_di = &{1'b0, io_di};

  assign wr_pend = io_we && (reg_e'(io_a) == REG_PEND);
  assign wr_mask = io_we && (reg_e'(io_a) == REG_MASK);
  assign wr_edge = io_we && (reg_e'(io_a) == REG_EDGE);

`ifdef IRQCTL_ROTATE_EN
  localparam logic [VECT_W-1:0] PTR_RST = VECT_W'(N_IRQ - 1);
  logic [VECT_W-1:0] ptr;

  // Round-robin pointer: remembers the last acknowledged in-range vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PTR_RST;
    end else if (irq_ack && (32'(irq_ack_vect) < N_IRQ)) begin
      ptr <= irq_ack_vect;
    end
  end
`endif

  // Next pending state: level sources follow the input; edge sources latch a
  // rising edge, and a new edge outranks a same-cycle ack or W1C so none is lost.
  // A mode change through EDGE clears that bit's pending state outright.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (mode[i]) begin
        pending_nxt[i] = (irq_in[i] && !irq_q[i]) ||
                         (pending[i] &&
                          !((irq_ack && (irq_ack_vect == VECT_W'(i))) ||
                            (wr_pend && io_di[i])));
      end else begin
        pending_nxt[i] = irq_in[i];
      end
      if (wr_edge && (io_di[i] != mode[i])) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // Controller state: pending, mask, mode and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      irq_q   <= '0;
    end else begin
      pending <= pending_nxt;
      irq_q   <= irq_in;
      if (wr_mask) begin
        enable <= io_di[N_IRQ-1:0];
      end
      if (wr_edge) begin
        mode <= io_di[N_IRQ-1:0];
      end
    end
  end

  // Priority selection among enabled pending sources.
`ifdef IRQCTL_ROTATE_EN
  int unsigned idx;
`endif
  always_comb begin
    req   = pending & enable;
    found = 1'b0;
    win   = '0;
`ifdef IRQCTL_ROTATE_EN
    idx   = 0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      idx = (32'(ptr) + 32'd1 + k) % N_IRQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = VECT_W'(idx);
      end
    end
`else
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        win   = VECT_W'(k);
      end
    end
`endif
  end

  assign iflag = found;
  assign ivect = win;

  // Read mux: combinational while io_re is high, zero otherwise.
  always_comb begin
    io_do = '0;
    if (io_re) begin
      case (reg_e'(io_a))
        REG_PEND: io_do[N_IRQ-1:0] = pending;
        REG_MASK: io_do[N_IRQ-1:0] = enable;
        REG_EDGE: io_do[N_IRQ-1:0] = mode;
        REG_STAT: begin
          io_do[7]          = iflag;
          io_do[VECT_W-1:0] = ivect;
        end
        default:  io_do = '0;
      endcase
    end
  end

endmodule
